vpu_cpu_bridge: RTL and testbench

- VPU-side end of the CPU↔VPU handoff; the counterpart to the CPU decode/execute stage.
- The CPU pulses VPU_start and drives vector registers V0–V7 plus the return object RO.
- This block snapshots them, streams them as a 9-beat command to the VPU core, and collects the core's results.
- It then returns the results to the CPU register file with a one-cycle we_VPU write and re-asserts VPU_rdy.

---
 rtl/vpu_cpu_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_vpu_cpu_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_cpu_bridge.sv
// vpu_cpu_bridge
//   VPU-side end of the CPU<->VPU handoff. On VPU_start (while idle) the CPU's
//   RO and V0..V7 are snapshotted and streamed to the VPU core as a 9-beat
//   command (beat 0 = RO, beats 1..8 = V0..V7). Result beats from the core
//   overwrite a copy of the snapshot by slot; on the last result the buffer is
//   registered onto V*_in/RO_in and we_VPU pulses for one cycle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   VPU_start             start request, honoured only while VPU_rdy=1
//   V0_out..V7_out,RO_out CPU register values captured at start
//   VPU_rdy               idle / able to accept a start
//   we_VPU                one-cycle write strobe for V0_in..V7_in, RO_in
//   V0_in..V7_in,RO_in    registered result words
//   core_op_*             command stream to the core (valid/ready, idx, data)
//   core_res_*            result stream from the core (valid/ready, idx, data, last)
//
// Build option
//   VPU_TIMEOUT_EN  adds a COLLECT watchdog of TIMEOUT_CYCLES cycles; on
//                   expiry the snapshot is written back with RO_in = all ones.
module vpu_cpu_bridge #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VPU_start,
  input  logic [DATA_W-1:0] V0_out,
  input  logic [DATA_W-1:0] V1_out,
  input  logic [DATA_W-1:0] V2_out,
  input  logic [DATA_W-1:0] V3_out,
  input  logic [DATA_W-1:0] V4_out,
  input  logic [DATA_W-1:0] V5_out,
  input  logic [DATA_W-1:0] V6_out,
  input  logic [DATA_W-1:0] V7_out,
  input  logic [DATA_W-1:0] RO_out,
  output logic              VPU_rdy,
  output logic              we_VPU,
  output logic [DATA_W-1:0] V0_in,
  output logic [DATA_W-1:0] V1_in,
  output logic [DATA_W-1:0] V2_in,
  output logic [DATA_W-1:0] V3_in,
  output logic [DATA_W-1:0] V4_in,
  output logic [DATA_W-1:0] V5_in,
  output logic [DATA_W-1:0] V6_in,
  output logic [DATA_W-1:0] V7_in,
  output logic [DATA_W-1:0] RO_in,
  output logic              core_op_valid,
  input  logic              core_op_ready,
  output logic [3:0]        core_op_idx,
  output logic [DATA_W-1:0] core_op_data,
  input  logic              core_res_valid,
  output logic              core_res_ready,
  input  logic [3:0]        core_res_idx,
  input  logic [DATA_W-1:0] core_res_data,
  input  logic              core_res_last
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_WB      = 2'd3;

  // Slot numbering shared by all word arrays: 0 = RO, 1..8 = V0..V7.
  logic [DATA_W-1:0] cpu_vec [9];
  logic [DATA_W-1:0] snap_q  [9];
  logic [DATA_W-1:0] snap_d  [9];
  logic [DATA_W-1:0] res_q   [9];
  logic [DATA_W-1:0] res_d   [9];
  logic [DATA_W-1:0] out_q   [9];
  logic [DATA_W-1:0] out_d   [9];

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

`ifdef VPU_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
`endif

  assign cpu_vec[0] = RO_out;
  assign cpu_vec[1] = V0_out;
  assign cpu_vec[2] = V1_out;
  assign cpu_vec[3] = V2_out;
  assign cpu_vec[4] = V3_out;
  assign cpu_vec[5] = V4_out;
  assign cpu_vec[6] = V5_out;
  assign cpu_vec[7] = V6_out;
  assign cpu_vec[8] = V7_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    res_d   = res_q;
    out_d   = out_q;
`ifdef VPU_TIMEOUT_EN
    wd_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (VPU_start) begin
          snap_d  = cpu_vec;
          res_d   = cpu_vec;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (core_op_ready) begin
          if (cnt_q == 4'd8) state_d = S_COLLECT;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      S_COLLECT: begin
`ifdef VPU_TIMEOUT_EN
        wd_d = wd_q + 16'd1;
`endif
        if (core_res_valid) begin
          // Slots 9..15 match no entry and are dropped; last is still honoured.
          for (int unsigned i = 0; i < 9; i++) begin
            if (core_res_idx == 4'(i)) res_d[i] = core_res_data;
          end
`ifdef VPU_TIMEOUT_EN
          wd_d = '0;
`endif
          // Load from res_d so the final beat's own write is included.
          if (core_res_last) begin
            out_d   = res_d;
            state_d = S_WB;
          end
        end
`ifdef VPU_TIMEOUT_EN
        else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          out_d    = snap_q;
          out_d[0] = '1;
          state_d  = S_WB;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '{default: '0};
      res_q   <= '{default: '0};
      out_q   <= '{default: '0};
`ifdef VPU_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      res_q   <= res_d;
      out_q   <= out_d;
`ifdef VPU_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

`ifndef VPU_TIMEOUT_EN
  // Watchdog compiled out; the parameter stays so both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  // All handshake outputs decode the state register only.
  assign VPU_rdy        = (state_q == S_IDLE);
  assign we_VPU         = (state_q == S_WB);
  assign core_op_valid  = (state_q == S_SEND);
  assign core_res_ready = (state_q == S_COLLECT);
  assign core_op_idx    = (state_q == S_SEND) ? cnt_q : 4'd0;

  always_comb begin
    core_op_data = '0;
    if (state_q == S_SEND) begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (cnt_q == 4'(i)) core_op_data = snap_q[i];
      end
    end
  end

  assign RO_in = out_q[0];
  assign V0_in = out_q[1];
  assign V1_in = out_q[2];
  assign V2_in = out_q[3];
  assign V3_in = out_q[4];
  assign V4_in = out_q[5];
  assign V5_in = out_q[6];
  assign V6_in = out_q[7];
  assign V7_in = out_q[8];

endmodule

// File: tb/tb_vpu_cpu_bridge.sv
// tb_vpu_cpu_bridge
//   Directed bench for vpu_cpu_bridge: reset values, command streaming with and
//   without back-pressure, result merging (pass-through, duplicates, dropped
//   slots), abort on reset, minimum latency and back-to-back starts, and the
//   watchdog when built with VPU_TIMEOUT_EN.
module tb_vpu_cpu_bridge;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          VPU_start = 1'b0;
  logic [DW-1:0] v_out [8];
  logic [DW-1:0] ro_out;
  logic          VPU_rdy, we_VPU;
  logic [DW-1:0] v_in [8];
  logic [DW-1:0] ro_in;
  logic          core_op_valid;
  logic          core_op_ready = 1'b0;
  logic [3:0]    core_op_idx;
  logic [DW-1:0] core_op_data;
  logic          core_res_valid = 1'b0;
  logic          core_res_ready;
  logic [3:0]    core_res_idx = 4'd0;
  logic [DW-1:0] core_res_data = '0;
  logic          core_res_last = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_v [8];
  logic [DW-1:0] exp_ro;
  logic [DW-1:0] beat_exp [9];
  logic [3:0]    r_idx [16];
  logic [DW-1:0] r_dat [16];

  always #5 clk = ~clk;

  vpu_cpu_bridge #(.DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .VPU_start(VPU_start),
    .V0_out(v_out[0]), .V1_out(v_out[1]), .V2_out(v_out[2]), .V3_out(v_out[3]),
    .V4_out(v_out[4]), .V5_out(v_out[5]), .V6_out(v_out[6]), .V7_out(v_out[7]),
    .RO_out(ro_out), .VPU_rdy(VPU_rdy), .we_VPU(we_VPU),
    .V0_in(v_in[0]), .V1_in(v_in[1]), .V2_in(v_in[2]), .V3_in(v_in[3]),
    .V4_in(v_in[4]), .V5_in(v_in[5]), .V6_in(v_in[6]), .V7_in(v_in[7]),
    .RO_in(ro_in),
    .core_op_valid(core_op_valid), .core_op_ready(core_op_ready),
    .core_op_idx(core_op_idx), .core_op_data(core_op_data),
    .core_res_valid(core_res_valid), .core_res_ready(core_res_ready),
    .core_res_idx(core_res_idx), .core_res_data(core_res_data),
    .core_res_last(core_res_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load_cpu(input logic [DW-1:0] ro, input logic [DW-1:0] base);
    ro_out = ro;
    exp_ro = ro;
    beat_exp[0] = ro;
    for (int i = 0; i < 8; i++) begin
      v_out[i]      = base + DW'(i + 1);
      exp_v[i]      = base + DW'(i + 1);
      beat_exp[i+1] = base + DW'(i + 1);
    end
  endtask

  // Called at a negedge with the bridge idle; returns one negedge after the start edge.
  task automatic start_txn(input string tag);
    VPU_start = 1'b1;
    @(negedge clk);
    VPU_start = 1'b0;
    chk({tag, "_rdy_low"}, 32'(VPU_rdy), 32'd0);
  endtask

  task automatic send_phase(input string tag, input bit toggle, input bit poke, output int cycles);
    int beat;
    beat   = 0;
    cycles = 0;
    core_op_ready = toggle ? 1'b0 : 1'b1;
    while (core_op_valid && cycles < 60) begin
      chk({tag, "_op_idx"}, 32'(core_op_idx), 32'(beat));
      if (beat < 9) chk({tag, "_op_data"}, 32'(core_op_data), 32'(beat_exp[beat]));
      if (core_op_ready) beat++;
      cycles++;
      if (poke) VPU_start = cycles[0];
      @(negedge clk);
      if (toggle) core_op_ready = ~core_op_ready;
    end
    VPU_start = 1'b0;
    core_op_ready = 1'b0;
    chk({tag, "_beats"}, 32'(beat), 32'd9);
    chk({tag, "_res_ready"}, 32'(core_res_ready), 32'd1);
  endtask

  task automatic collect(input int n, input bit poke);
    for (int k = 0; k < n; k++) begin
      core_res_valid = 1'b1;
      core_res_idx   = r_idx[k];
      core_res_data  = r_dat[k];
      core_res_last  = (k == n - 1);
      VPU_start      = poke && k[0];
      @(negedge clk);
    end
    core_res_valid = 1'b0;
    core_res_last  = 1'b0;
    VPU_start      = 1'b0;
  endtask

  task automatic wb_check(input string tag);
    chk({tag, "_we"}, 32'(we_VPU), 32'd1);
    chk({tag, "_ro_in"}, 32'(ro_in), 32'(exp_ro));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_v%0d_in", tag, i), 32'(v_in[i]), 32'(exp_v[i]));
    @(negedge clk);
    chk({tag, "_we_one_cycle"}, 32'(we_VPU), 32'd0);
    chk({tag, "_rdy_back"}, 32'(VPU_rdy), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, n, pulses;
    load_cpu(16'h0000, 16'h0000);

    // Reset state
    @(negedge clk);
    chk("rst_rdy", 32'(VPU_rdy), 32'd1);
    chk("rst_we", 32'(we_VPU), 32'd0);
    chk("rst_op_valid", 32'(core_op_valid), 32'd0);
    chk("rst_res_ready", 32'(core_res_ready), 32'd0);
    chk("rst_op_idx", 32'(core_op_idx), 32'd0);
    chk("rst_op_data", 32'(core_op_data), 32'd0);
    chk("rst_ro_in", 32'(ro_in), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_v%0d_in", i), 32'(v_in[i]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full result set, core always ready
    load_cpu(16'h00AA, 16'h0000);
    start_txn("basic");
    send_phase("basic", 1'b0, 1'b0, cyc);
    chk("basic_send_cycles", 32'(cyc), 32'd9);
    for (int i = 0; i < 8; i++) begin
      r_idx[i] = 4'(i + 1);
      r_dat[i] = 16'h1001 + DW'(i);
      exp_v[i] = 16'h1001 + DW'(i);
    end
    r_idx[8] = 4'd0; r_dat[8] = 16'h55AA; exp_ro = 16'h55AA;
    collect(9, 1'b0);
    wb_check("basic");

    // Reset during SEND beat 4
    load_cpu(16'h3333, 16'h0200);
    start_txn("abort");
    core_op_ready = 1'b1;
    n = 0;
    while (core_op_idx != 4'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_beat4", 32'(core_op_idx), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_op_valid", 32'(core_op_valid), 32'd0);
    chk("abort_rdy", 32'(VPU_rdy), 32'd1);
    chk("abort_we", 32'(we_VPU), 32'd0);
    chk("abort_ro_in", 32'(ro_in), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("abort_v%0d_in", i), 32'(v_in[i]), 32'd0);
    core_op_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    core_op_ready = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (we_VPU || !VPU_rdy) pulses++;
    end
    chk("abort_no_activity", 32'(pulses), 32'd0);
    core_op_ready = 1'b0;

    // Single result into V2 slot; everything else passes through
    load_cpu(16'h1234, 16'h0000);
    start_txn("single");
    send_phase("single", 1'b0, 1'b0, cyc);
    r_idx[0] = 4'd3; r_dat[0] = 16'hBEEF;
    exp_v[2] = 16'hBEEF;
    collect(1, 1'b0);
    wb_check("single");

    // Back-pressure, ignored starts, duplicate slot, dropped slot, last on slot 15
    load_cpu(16'h0F0F, 16'h0100);
    start_txn("stall");
    send_phase("stall", 1'b1, 1'b1, cyc);
    chk("stall_send_cycles", 32'(cyc), 32'd18);
    r_idx[0] = 4'd5;  r_dat[0] = 16'h1111;
    r_idx[1] = 4'd5;  r_dat[1] = 16'h2222;
    r_idx[2] = 4'd9;  r_dat[2] = 16'hDEAD;
    r_idx[3] = 4'd1;  r_dat[3] = 16'h00C3;
    r_idx[4] = 4'd15; r_dat[4] = 16'hBAD0;
    exp_v[4] = 16'h2222;
    exp_v[0] = 16'h00C3;
    collect(5, 1'b1);
    wb_check("stall");
    @(negedge clk);
    chk("stall_start_not_queued", 32'(VPU_rdy), 32'd1);

    // Minimum latency with start held high for a back-to-back transaction
    load_cpu(16'h0A0A, 16'h0010);
    core_op_ready  = 1'b1;
    core_res_valid = 1'b1;
    core_res_idx   = 4'd0;
    core_res_data  = 16'h7777;
    core_res_last  = 1'b1;
    exp_ro = 16'h7777;
    VPU_start = 1'b1;
    @(negedge clk);
    chk("lat_rdy_low", 32'(VPU_rdy), 32'd0);
    n = 0;
    while (!we_VPU && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("lat_cycles", 32'(n), 32'd10);
    chk("lat_ro_in", 32'(ro_in), 32'h7777);
    chk("lat_v7_in", 32'(v_in[7]), 32'h0018);
    @(negedge clk);
    chk("b2b_rdy_idle", 32'(VPU_rdy), 32'd1);
    @(negedge clk);
    chk("b2b_rdy_low", 32'(VPU_rdy), 32'd0);
    chk("b2b_op_valid", 32'(core_op_valid), 32'd1);
    chk("b2b_op_data", 32'(core_op_data), 32'h0A0A);
    VPU_start = 1'b0;
    n = 0;
    while (!we_VPU && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_cycles", 32'(n), 32'd10);
    core_res_valid = 1'b0;
    core_res_last  = 1'b0;
    core_op_ready  = 1'b0;
    @(negedge clk);
    chk("b2b_rdy_back", 32'(VPU_rdy), 32'd1);

`ifdef VPU_TIMEOUT_EN
    // Watchdog: no results at all
    load_cpu(16'h4444, 16'h0300);
    start_txn("wd");
    send_phase("wd", 1'b0, 1'b0, cyc);
    n = 0;
    while (core_res_ready && !we_VPU && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wd_collect_cycles", 32'(n), 32'd16);
    exp_ro = 16'hFFFF;
    wb_check("wd");
    core_res_valid = 1'b1;
    core_res_last  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (we_VPU || !VPU_rdy) pulses++;
    end
    chk("wd_late_last_ignored", 32'(pulses), 32'd0);
    core_res_valid = 1'b0;
    core_res_last  = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
